// File: rtl/pending_event_encoder_pkg.sv
// Shared types and width helpers for the pending event encoder.
package pending_event_encoder_pkg;

  typedef enum logic {IDLE, OFFER} pee_state_t;

  // Index width for n lines, never smaller than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pending_event_encoder_rr_find_first.sv
// Combinational search: first set bit of vec at or above start, wrapping around.
module rr_find_first
  import pending_event_encoder_pkg::*;
#(
  parameter int unsigned EncodeWidth = 4,
  parameter int unsigned DecodeWidth = 2 ** EncodeWidth
) (
  input  logic [DecodeWidth-1:0] vec,
  input  logic [EncodeWidth-1:0] start,
  output logic [EncodeWidth-1:0] idx,
  output logic                   found
);

  localparam int unsigned PosW = idx_width(DecodeWidth);

  logic [PosW-1:0] pos;
  logic [PosW-1:0] j;

  always_comb begin
    found = 1'b0;
    pos   = '0;
    j     = '0;
    for (int i = 0; i < DecodeWidth; i++) begin
      j = PosW'((int'(start) + i) % DecodeWidth);
      if (!found && vec[j]) begin
        found = 1'b1;
        pos   = j;
      end
    end
  end

  assign idx = EncodeWidth'(pos);

endmodule

// File: rtl/pending_event_encoder.sv
// Collects event pulses into sticky pending bits and offers them one index at a time
// over a valid/ready handshake, lowest-first or round-robin.
module pending_event_encoder
  import pending_event_encoder_pkg::*;
#(
  parameter int unsigned EncodeWidth = 4,
  parameter int unsigned DecodeWidth = 2 ** EncodeWidth,
  parameter bit          RoundRobin  = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DecodeWidth-1:0] REQ,
  input  logic                   CLR_ALL,
  output logic [EncodeWidth-1:0] OUT_IDX,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [DecodeWidth-1:0] PENDING,
  output logic                   OVERRUN
);

  pee_state_t             state_q, state_d;
  logic [DecodeWidth-1:0] pending_q, pending_d;
  logic [EncodeWidth-1:0] idx_q, idx_d;
  logic [EncodeWidth-1:0] ptr_q, ptr_d;
  logic                   overrun_q, overrun_d;

  logic                   handshake;
  logic [DecodeWidth-1:0] served;
  logic [DecodeWidth-1:0] cand;
  logic [EncodeWidth-1:0] last;
  logic [EncodeWidth-1:0] start;
  logic [EncodeWidth-1:0] next_idx;
  logic                   found;

  assign handshake = (state_q == OFFER) && OUT_READY;

  always_comb begin
    served = '0;
    for (int i = 0; i < DecodeWidth; i++) begin
      served[i] = handshake && (idx_q == EncodeWidth'(i));
    end
  end

  assign cand = pending_q & ~served;

  // A grant in this cycle counts as the last grant, so the search already starts above it.
  assign last  = handshake ? idx_q : ptr_q;
  assign start = !RoundRobin ? '0 :
                 (last == EncodeWidth'(DecodeWidth - 1)) ? '0 : last + 1'b1;

  rr_find_first #(
    .EncodeWidth(EncodeWidth),
    .DecodeWidth(DecodeWidth)
  ) u_find (
    .vec  (cand),
    .start(start),
    .idx  (next_idx),
    .found(found)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      ptr_q     <= EncodeWidth'(DecodeWidth - 1);
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = handshake ? idx_q : ptr_q;
    pending_d = cand | REQ;
    overrun_d = |(REQ & cand);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = next_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (OUT_READY) begin
          if (found) idx_d = next_idx;
          else       state_d = IDLE;
        end
      end
    endcase
    // Flush wins over everything except the pointer, which still tracks a completed grant.
    if (CLR_ALL) begin
      state_d   = IDLE;
      idx_d     = idx_q;
      pending_d = '0;
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    OUT_VALID = (state_q == OFFER);
    OUT_IDX   = idx_q;
    PENDING   = pending_q;
    OVERRUN   = overrun_q;
  end

endmodule
